load_store_unit: RTL and testbench

Initiator-side controller for the CPU data memory. It accepts byte, halfword and word load/store requests from the MIPS pipeline and drives the word-addressed memory port. The memory port has synchronous read with one-cycle latency and an active-low write enable.
- Loads: sign or zero extension.
- Sub-word stores: read-modify-write.
- Misaligned accesses: flagged with an error; memory is not touched.

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Load/store unit bus: pipeline request/response plus data-memory port.
// slave = the unit; master = pipeline + memory side.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_dataIn;
    logic                  mem_we;
    logic [31:0]           mem_dataOut;

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata, mem_dataOut,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_address, mem_dataIn, mem_we
    );

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata, mem_dataOut,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_address, mem_dataIn, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads (sign/zero ext), RMW sub-word stores.
// Ports: clk, rst_n (async low), bus (slave) = request/response + memory port.
module load_store_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic clk,
    input  logic rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD_DATA, RMW_MERGE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [1:0]            r_lane;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [15:0]           r_wdata;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [31:0]           r_rsp_rdata;

    logic                  w_accept;
    logic                  w_misal;
    logic                  w_wstore;
    logic                  w_we;
    logic [31:0]           w_din;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [4:0]            w_sh;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ext;
    logic [31:0]           w_merge;

    assign w_misal = (bus.req_size == 2'd3)
                   | ((bus.req_size == 2'd1) & bus.req_addr[0])
                   | ((bus.req_size == 2'd2) & (|bus.req_addr[1:0]));
    assign w_accept = bus.req_valid & (r_state == IDLE);
    assign w_wstore = w_accept & bus.req_write & ~w_misal
                    & (bus.req_size == 2'd2);

    // Lane extraction and merge both work on the latched lane.
    assign w_sh   = {r_lane, 3'b000};
    assign w_byte = bus.mem_dataOut[w_sh +: 8];
    assign w_half = r_lane[1] ? bus.mem_dataOut[31:16]
                              : bus.mem_dataOut[15:0];

    always_comb begin
        w_ext = bus.mem_dataOut;
        if (r_size == 2'd0)
            w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
        else if (r_size == 2'd1)
            w_ext = {{16{r_signed & w_half[15]}}, w_half};
    end

    always_comb begin
        w_merge = bus.mem_dataOut;
        if (r_size == 2'd0)
            w_merge[w_sh +: 8] = r_wdata[7:0];
        else if (r_lane[1])
            w_merge[31:16] = r_wdata;
        else
            w_merge[15:0] = r_wdata;
    end

    always_comb begin
        w_next = r_state;
        w_we   = 1'b1;
        w_din  = 32'd0;
        w_addr = r_waddr;
        unique case (r_state)
            IDLE: begin
                w_addr = bus.req_addr[ADDR_WIDTH+1:2];
                if (w_wstore) begin
                    w_we  = 1'b0;
                    w_din = bus.req_wdata;
                end
                if (w_accept && !w_misal && !w_wstore)
                    w_next = bus.req_write ? RMW_MERGE : LOAD_DATA;
            end
            LOAD_DATA: w_next = IDLE;
            RMW_MERGE: begin
                w_we   = 1'b0;
                w_din  = w_merge;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_waddr     <= '0;
            r_lane      <= 2'd0;
            r_size      <= 2'd0;
            r_signed    <= 1'b0;
            r_wdata     <= 16'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_waddr  <= bus.req_addr[ADDR_WIDTH+1:2];
                r_lane   <= bus.req_addr[1:0];
                r_size   <= bus.req_size;
                r_signed <= bus.req_signed;
                r_wdata  <= bus.req_wdata[15:0];
            end
            unique case (r_state)
                IDLE: begin
                    if (w_accept && (w_misal || w_wstore)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_misal;
                        r_rsp_rdata <= 32'd0;
                    end
                end
                LOAD_DATA: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= w_ext;
                end
                RMW_MERGE: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.mem_address = w_addr;
    assign bus.mem_dataIn  = w_din;
    // Reset forces the write enable off at once, independent of the clock.
    assign bus.mem_we      = w_we | ~rst_n;
endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: vector table + response scoreboard,
// behavioural synchronous memory, reset-during-RMW sequence.
module tb_load_store_unit;
    localparam int AW = 10;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eerr;
        int          lat;
        logic        ewe;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    logic load_en;
    int   cyc;
    int   n_chk;
    int   n_err;
    exp_t sbq[$];
    vec_t tv[15];

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] raddr;

    load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: write then register address, so a read of a
    // just-written word returns the new data.
    always @(posedge clk) begin
        if (load_en) begin
            mem[0] <= 32'h0000_07D1;
            mem[1] <= 32'h0000_0FA1;
            mem[2] <= 32'h0000_1389;
            mem[3] <= 32'h0000_0000;
        end else if (!bus.mem_we) begin
            mem[bus.mem_address] <= bus.mem_dataIn;
        end
        raddr <= bus.mem_address;
    end
    assign bus.mem_dataOut = mem[raddr];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_rdata"}, bus.rsp_rdata, e.rd);
                check({e.name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
                check({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    function automatic vec_t mk(logic wr, logic [1:0] sz, logic sg,
                                logic [11:0] a, logic [31:0] wd,
                                logic [31:0] erd, logic eerr,
                                int lat, logic ewe);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sg = sg; v.addr = a; v.wd = wd;
        v.erd = erd; v.eerr = eerr; v.lat = lat; v.ewe = ewe;
        return v;
    endfunction

    task automatic do_req(input vec_t v, input string nm, input bit push);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            check({nm, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        bus.req_valid  = 1'b1;
        bus.req_write  = v.wr;
        bus.req_size   = v.sz;
        bus.req_signed = v.sg;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wd;
        #1;
        check({nm, "_accept_we"}, {31'd0, bus.mem_we}, {31'd0, v.ewe});
        @(posedge clk);
        #1;
        if (push)
            sbq.push_back('{v.erd, v.eerr, cyc + v.lat - 1, nm});
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int k;
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 12'd0;
        bus.req_wdata  = 32'd0;
        rst_n   = 1'b0;
        load_en = 1'b1;

        tv[0]  = mk(0, 2, 0, 12'h004, 0, 32'h0000_0FA1, 0, 2, 1);
        tv[1]  = mk(0, 0, 1, 12'h004, 0, 32'hFFFF_FFA1, 0, 2, 1);
        tv[2]  = mk(0, 0, 0, 12'h004, 0, 32'h0000_00A1, 0, 2, 1);
        tv[3]  = mk(0, 1, 0, 12'h006, 0, 32'h0000_0000, 0, 2, 1);
        tv[4]  = mk(0, 2, 0, 12'h008, 0, 32'hBEEF_1389, 0, 2, 1);
        tv[5]  = mk(1, 2, 0, 12'h00C, 32'hDEAD_BEEF, 0, 0, 1, 0);
        tv[6]  = mk(0, 2, 0, 12'h00C, 0, 32'hDEAD_BEEF, 0, 2, 1);
        tv[7]  = mk(0, 2, 0, 12'h006, 0, 0, 1, 1, 1);
        tv[8]  = mk(1, 1, 0, 12'h001, 32'h0000_1234, 0, 1, 1, 1);
        tv[9]  = mk(0, 3, 0, 12'h000, 0, 0, 1, 1, 1);
        tv[10] = mk(0, 1, 1, 12'h00A, 0, 32'hFFFF_BEEF, 0, 2, 1);
        tv[11] = mk(0, 0, 1, 12'h00E, 0, 32'hFFFF_FFAD, 0, 2, 1);
        tv[12] = mk(1, 0, 0, 12'h00D, 32'h0000_0077, 0, 0, 2, 1);
        tv[13] = mk(0, 2, 0, 12'h00C, 0, 32'hDEAD_77EF, 0, 2, 1);
        tv[14] = mk(0, 0, 0, 12'h00F, 0, 32'h0000_00DE, 0, 2, 1);

        repeat (2) @(posedge clk);
        load_en = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
        check("rst_we", {31'd0, bus.mem_we}, 32'd1);
        rst_n = 1'b1;

        // Half store into word 2: merge visible in the RMW cycle.
        do_req(mk(1, 1, 0, 12'h00A, 32'h0000_BEEF, 0, 0, 2, 1),
               "rmw_half", 1'b1);
        @(negedge clk);
        check("rmw_we", {31'd0, bus.mem_we}, 32'd0);
        check("rmw_dataIn", bus.mem_dataIn, 32'hBEEF_1389);

        for (int i = 0; i < 15; i++)
            do_req(tv[i], $sformatf("v%0d", i), 1'b1);

        // Reset in the middle of a byte store read-modify-write.
        k = 0;
        while (sbq.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        do_req(mk(1, 0, 0, 12'h000, 32'h0000_0055, 0, 0, 2, 1),
               "rst_rmw", 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstrmw_we", {31'd0, bus.mem_we}, 32'd1);
        check("rstrmw_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rstrmw_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        check("rstrmw_word0", mem[0], 32'h0000_07D1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstrmw_ready", {31'd0, bus.req_ready}, 32'd1);
        do_req(mk(0, 2, 0, 12'h000, 0, 32'h0000_07D1, 0, 2, 1),
               "rstrmw_load", 1'b1);

        k = 0;
        while (sbq.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0)
            check("rsp_timeout", sbq.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
